// File: rtl/shift_reg_univ_if.sv
// Bus bundle for shift_reg_univ.
// Carries the rot input only when SHIFTREG_ROTATE_EN is defined.
interface shift_reg_univ_if #(
  parameter int WIDTH = 8
) ();
  logic             Din;
  logic             shift_ena;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] Pin;
  logic             start;
`ifdef SHIFTREG_ROTATE_EN
  logic             rot;
`endif
  logic             Qout;
  logic [WIDTH-1:0] Pout;
  logic             busy;
  logic             done;

  modport master (
    output Din, shift_ena, dir, load, Pin, start,
`ifdef SHIFTREG_ROTATE_EN
    output rot,
`endif
    input  Qout, Pout, busy, done
  );

  modport slave (
    input  Din, shift_ena, dir, load, Pin, start,
`ifdef SHIFTREG_ROTATE_EN
    input  rot,
`endif
    output Qout, Pout, busy, done
  );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal shift register: load, manual shift, autonomous burst.
// Optional rotate mode via SHIFTREG_ROTATE_EN.
module shift_reg_univ #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  shift_reg_univ_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic             done_r;
  logic             dir_l;
  logic             eff_dir;
  logic             exit_bit;
  logic             in_bit;
  logic [WIDTH-1:0] shifted;

  assign eff_dir  = busy_r ? dir_l : bus.dir;
  assign exit_bit = eff_dir ? q[0] : q[WIDTH-1];

`ifdef SHIFTREG_ROTATE_EN
  assign in_bit = bus.rot ? exit_bit : bus.Din;
`else
  assign in_bit = bus.Din;
`endif

  assign shifted = eff_dir ? {in_bit, q[WIDTH-1:1]}
                           : {q[WIDTH-2:0], in_bit};

  always_ff @(posedge clk) begin
    if (!rst) begin
      q      <= RST_VAL;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dir_l  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (busy_r) begin
        q   <= shifted;
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end else begin
        priority case (1'b1)
          bus.load: q <= bus.Pin;
          bus.start: begin
            dir_l  <= bus.dir;
            cnt    <= CNT_W'(WIDTH);
            busy_r <= 1'b1;
          end
          bus.shift_ena: q <= shifted;
          default: ;
        endcase
      end
    end
  end

  assign bus.Qout = exit_bit;
  assign bus.Pout = q;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
endmodule
